counter_sweep_ctrl: RTL and testbench
=====================================

# counter_sweep_ctrl

Sequencer and two-way arbiter for the shared 8-bit up/down/load counter. Two requesters each post a sweep (start value, end value); the block grants one at a time round-robin, loads the counter with the start value, steers `up` every cycle until the counter reaches the end value, then freezes the counter and reports completion. It sits between the requesting control logic and the counter's `load`/`up`/`cin` inputs, and observes the counter's `cout`.

## Interface

**Parameters**
- `WIDTH`, default 8: counter and value width. Must match the counter instance.

**Ports**
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `req0`, `req1` in 1: sweep request, level. Held high until the matching `gnt` pulse.
- `from0`, `to0`, `from1`, `to1` in WIDTH: sweep bounds. Sampled only in the grant cycle.
- `abort` in 1: terminate the active sweep.
- `gnt` out 2: one-hot, 1-cycle grant pulse.
- `busy` out 1: sweep in progress (LOAD or RUN).
- `done` out 1: 1-cycle completion pulse.
- `done_id` out 1: requester that owned the completed sweep. Valid with `done`.
- `done_abort` out 1: the completion was caused by `abort`. Valid with `done`.
- `cnt_load` out 1: to counter `load`.
- `cnt_up` out 1: to counter `up`.
- `cnt_cin` out WIDTH: to counter `cin`.
- `cnt_q` in WIDTH: from counter `cout`.

## Operation

- **FSM states:** IDLE, LOAD, RUN, DONE. Registered state; counter-side outputs are combinational from state and `cnt_q`.
- **Holding the counter:** the counter has no enable, so a hold is `cnt_load=1`, `cnt_cin=cnt_q`. This applies in IDLE and DONE, and while `rst` is asserted.
- **IDLE:**
  - If any `req` is high, pick the winner: the other requester than the last one granted has priority. After reset, req0 has priority.
  - Latch `from`/`to`/id into registers, pulse `gnt[id]`, and go to LOAD.
  - Direction: `dir_up = (to >= from)`, unsigned.
- **LOAD:** `cnt_load=1`, `cnt_cin=from_r`. Next state RUN.
- **RUN:**
  - If `cnt_q == to_r`: `cnt_load=1`, `cnt_cin=to_r` (freeze). Next state DONE, `done_abort=0`.
  - Otherwise: `cnt_load=0`, `cnt_up=dir_up`. The counter steps by 1 on each edge.
- **DONE:** `done=1` for one cycle, `done_id=id_r`. Hold the counter. Next state IDLE. No grant is issued in DONE.
- **abort:**
  - In LOAD or RUN, `abort` wins over everything else that cycle: hold the counter at `cnt_q` and go to DONE with `done_abort=1`.
  - Ignored in IDLE and DONE.
- **Simultaneous events:**
  - `req0` and `req1` both high: the priority requester wins. The loser stays pending and is served next.
  - `abort` in the same cycle as equality: report as an abort.
- **Wrap-around:** the counter wraps modulo 2^WIDTH on its own. Without the macro, direction never requires a wrap.
- **Degenerate sweep** (`from == to`): one RUN cycle, then DONE.
- **Reset mid-sweep:** FSM returns to IDLE immediately; no `done` is issued.
- **Reset values:** state=IDLE, `gnt=0`, `busy=0`, `done=0`, `done_id=0`, `done_abort=0`, priority=req0, `cnt_load=1`, `cnt_up=0`, `cnt_cin=cnt_q`.

## Timing

- **Request to grant:** `req` high in IDLE → `gnt` in the same cycle (combinational from the registered state).
- **Load:** `cnt_q == from` on the edge after LOAD.
- **RUN length:** N+1 cycles, where N = step count (|to−from| without the macro).
- **Grant to done:** `done` asserts N+3 cycles after `gnt`.
- **Back-to-back service:** minimum spacing between successive grants is N+4 cycles (IDLE, LOAD, RUN×(N+1), DONE).
- **Counter stability:** `cnt_q` holds `to` from the first DONE cycle until the next LOAD.

## Configuration

- **`COUNTER_SWEEP_CTRL_WRAP_EN` defined:**
  - Direction takes the shortest modular path.
  - `d_up = (to − from) mod 2^WIDTH`, `d_dn = (from − to) mod 2^WIDTH`.
  - `dir_up = (d_up <= d_dn)`; a tie goes up.
  - N = min(`d_up`, `d_dn`).
- **Undefined:** direction comes from the unsigned compare `to >= from`. Sweeps never cross the 255↔0 boundary.

## Test plan

- **Basic up sweep:** `req0=1`, `from0=3`, `to0=7`, one requester.
  - `gnt=01` at cycle 0, `cnt_q` 3,4,5,6,7 over RUN.
  - `done=1`, `done_id=0`, `done_abort=0` at cycle 7; `cnt_q` then holds at 7.
- **Down sweep and degenerate:** `from=10`, `to=4` → `cnt_q` steps down 10..4, `done` after 9 cycles. Then `from=to=0x55` → `done` 3 cycles after `gnt`.
- **Round-robin:** `req0` and `req1` held high continuously after reset → grants alternate `01`,`10`,`01`. Each grant appears exactly one cycle after the previous `done`.
- **Abort:** `abort` pulsed with `cnt_q=0x20` during an up sweep 0x10→0x40.
  - Next cycle `done=1`, `done_abort=1`.
  - `cnt_q` stays 0x20 through IDLE.
- **Wrap:** `from=250`, `to=3`.
  - Without the macro: down sweep, `done` 250 cycles after `gnt`.
  - With `COUNTER_SWEEP_CTRL_WRAP_EN`: `cnt_q` = 250..255,0..3, `done` 12 cycles after `gnt`.
- **Reset mid-RUN:** assert `rst` during a sweep → `busy=0`, `cnt_load=1` asynchronously, no `done`. After release, `req1` pending with `req0` → req0 granted first.

Source files
------------

// File: rtl/counter_sweep_ctrl_if.sv
// Bundle between requesting control logic, the sweep sequencer and the shared
// up/down/load counter. The slave modport is the sequencer's view.
interface counter_sweep_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] from0;
    logic [WIDTH-1:0] to0;
    logic [WIDTH-1:0] from1;
    logic [WIDTH-1:0] to1;
    logic             abort;
    logic [1:0]       gnt;
    logic             busy;
    logic             done;
    logic             done_id;
    logic             done_abort;
    logic             cnt_load;
    logic             cnt_up;
    logic [WIDTH-1:0] cnt_cin;
    logic [WIDTH-1:0] cnt_q;

    modport slave (
        input  req0, req1, from0, to0, from1, to1, abort, cnt_q,
        output gnt, busy, done, done_id, done_abort, cnt_load, cnt_up, cnt_cin
    );

    modport master (
        output req0, req1, from0, to0, from1, to1, abort, cnt_q,
        input  gnt, busy, done, done_id, done_abort, cnt_load, cnt_up, cnt_cin
    );
endinterface

// File: rtl/counter_sweep_ctrl.sv
// Round-robin sweep sequencer driving a shared up/down/load counter.
// Define COUNTER_SWEEP_CTRL_WRAP_EN to sweep along the shortest modular path.
module counter_sweep_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    counter_sweep_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             prio_q, prio_d;
    logic             id_q, id_d;
    logic             abort_q, abort_d;
    logic             dir_up_q, dir_up_d;
    logic [WIDTH-1:0] from_q, from_d;
    logic [WIDTH-1:0] to_q, to_d;

    logic             win_vld;
    logic             win_id;
    logic [WIDTH-1:0] sel_from;
    logic [WIDTH-1:0] sel_to;

    function automatic logic sweep_dir_up(input logic [WIDTH-1:0] from_v,
                                          input logic [WIDTH-1:0] to_v);
`ifdef COUNTER_SWEEP_CTRL_WRAP_EN
        logic [WIDTH-1:0] d_up;
        logic [WIDTH-1:0] d_dn;
        d_up = to_v - from_v;
        d_dn = from_v - to_v;
        return (d_up <= d_dn);
`else
        return (to_v >= from_v);
`endif
    endfunction

    // prio_q=1 means req1 currently holds priority; a lone requester always wins
    always_comb begin
        win_vld  = bus.req0 | bus.req1;
        win_id   = (bus.req0 && bus.req1) ? prio_q : bus.req1;
        sel_from = win_id ? bus.from1 : bus.from0;
        sel_to   = win_id ? bus.to1   : bus.to0;
    end

    always_comb begin
        state_d        = state_q;
        prio_d         = prio_q;
        id_d           = id_q;
        abort_d        = abort_q;
        dir_up_d       = dir_up_q;
        from_d         = from_q;
        to_d           = to_q;
        bus.gnt        = 2'b00;
        bus.busy       = 1'b0;
        bus.done       = 1'b0;
        bus.done_id    = 1'b0;
        bus.done_abort = 1'b0;
        bus.cnt_load   = 1'b1;
        bus.cnt_up     = 1'b0;
        bus.cnt_cin    = bus.cnt_q;

        case (state_q)
            S_IDLE: begin
                if (win_vld && !rst) begin
                    bus.gnt  = win_id ? 2'b10 : 2'b01;
                    id_d     = win_id;
                    prio_d   = ~win_id;
                    from_d   = sel_from;
                    to_d     = sel_to;
                    dir_up_d = sweep_dir_up(sel_from, sel_to);
                    abort_d  = 1'b0;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                bus.busy = 1'b1;
                if (bus.abort) begin
                    abort_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    bus.cnt_cin = from_q;
                    state_d     = S_RUN;
                end
            end
            S_RUN: begin
                bus.busy = 1'b1;
                if (bus.abort) begin
                    abort_d = 1'b1;
                    state_d = S_DONE;
                end else if (bus.cnt_q == to_q) begin
                    bus.cnt_cin = to_q;
                    abort_d     = 1'b0;
                    state_d     = S_DONE;
                end else begin
                    bus.cnt_load = 1'b0;
                    bus.cnt_up   = dir_up_q;
                end
            end
            S_DONE: begin
                bus.done       = 1'b1;
                bus.done_id    = id_q;
                bus.done_abort = abort_q;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            prio_q  <= 1'b0;
            id_q    <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            id_q    <= id_d;
            abort_q <= abort_d;
        end
    end

    // Sweep bounds are only consumed after a grant reloads them
    always_ff @(posedge clk) begin
        from_q   <= from_d;
        to_q     <= to_d;
        dir_up_q <= dir_up_d;
    end

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Bench for counter_sweep_ctrl: behavioural counter plus a step/direction model
// of each sweep, with randomized sweeps and the directed corner cases.
module tb_counter_sweep_ctrl;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    counter_sweep_ctrl_if #(.WIDTH(W)) bus ();
    counter_sweep_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    // The shared counter: load wins, otherwise step up or down every edge
    logic [W-1:0] ctr = '0;
    always @(posedge clk) begin
        if (bus.cnt_load)    ctr <= bus.cnt_cin;
        else if (bus.cnt_up) ctr <= ctr + 1'b1;
        else                 ctr <= ctr - 1'b1;
    end
    assign bus.cnt_q = ctr;

    int vectors = 0;
    int miscompares = 0;

    logic [1:0]   obs_gnt;
    int           obs_done_cyc;
    logic         obs_done_id;
    logic         obs_done_abort;
    logic [W-1:0] obs_cnt[$];
    logic         obs_busy[$];
    int           obs_extra_gnt;
    logic [W-1:0] obs_idle_cnt;
    logic         obs_idle_busy;

    function automatic int model_steps(int f, int t);
`ifdef COUNTER_SWEEP_CTRL_WRAP_EN
        int du;
        int dd;
        du = (t - f + 256) % 256;
        dd = (f - t + 256) % 256;
        return (du <= dd) ? du : dd;
`else
        return (t >= f) ? t - f : f - t;
`endif
    endfunction

    function automatic int model_dir(int f, int t);
`ifdef COUNTER_SWEEP_CTRL_WRAP_EN
        int du;
        int dd;
        du = (t - f + 256) % 256;
        dd = (f - t + 256) % 256;
        return (du <= dd) ? 1 : -1;
`else
        return (t >= f) ? 1 : -1;
`endif
    endfunction

    function automatic int model_val(int f, int dir, int c);
        return (f + dir * (c - 2) + 512) % 256;
    endfunction

    // Runs one sweep from IDLE and records observations; ends in the IDLE after DONE
    task automatic do_sweep(input logic id, input logic [W-1:0] f, input logic [W-1:0] t,
                            input int abort_cyc);
        obs_cnt.delete();
        obs_busy.delete();
        obs_done_cyc   = -1;
        obs_done_id    = 1'b0;
        obs_done_abort = 1'b0;
        obs_extra_gnt  = 0;
        if (id == 1'b0) begin
            bus.from0 = f; bus.to0 = t; bus.req0 = 1'b1;
        end else begin
            bus.from1 = f; bus.to1 = t; bus.req1 = 1'b1;
        end
        #1;
        obs_gnt = bus.gnt;
        for (int c = 0; c < 600; c++) begin
            obs_cnt.push_back(bus.cnt_q);
            obs_busy.push_back(bus.busy);
            if (c > 0 && bus.gnt != 2'b00) obs_extra_gnt++;
            if (bus.done) begin
                obs_done_cyc   = c;
                obs_done_id    = bus.done_id;
                obs_done_abort = bus.done_abort;
                break;
            end
            bus.abort = (c == abort_cyc);
            @(posedge clk); #1;
            bus.abort = 1'b0;
            bus.req0  = 1'b0;
            bus.req1  = 1'b0;
        end
        if (obs_done_cyc >= 0) begin
            @(posedge clk); #1;
            obs_idle_cnt  = bus.cnt_q;
            obs_idle_busy = bus.busy;
        end
    endtask

    task automatic test_reset();
        #1;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.gnt !== 2'b00 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: gnt=%b busy=%b done=%b want 00/0/0", bus.gnt, bus.busy, bus.done);
        end
        vectors++;
        if (bus.done_id !== 1'b0 || bus.done_abort !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_done_info: id=%b abort=%b want 0/0", bus.done_id, bus.done_abort);
        end
        vectors++;
        if (bus.cnt_load !== 1'b1 || bus.cnt_up !== 1'b0 || bus.cnt_cin !== bus.cnt_q) begin
            miscompares++;
            $display("FAIL reset_hold: load=%b up=%b cin=%0d q=%0d want 1/0/cin==q",
                     bus.cnt_load, bus.cnt_up, bus.cnt_cin, bus.cnt_q);
        end
        @(posedge clk); @(posedge clk); #1;
        vectors++;
        if (bus.gnt !== 2'b00 || bus.cnt_q !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_held: gnt=%b cnt_q=%0d want 00/0", bus.gnt, bus.cnt_q);
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (bus.busy !== 1'b0 || bus.cnt_load !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_idle: busy=%b load=%b want 0/1", bus.busy, bus.cnt_load);
        end
    endtask

    task automatic test_up_sweep();
        do_sweep(1'b0, 8'd3, 8'd7, -1);
        vectors++;
        if (obs_gnt !== 2'b01) begin
            miscompares++; $display("FAIL up_gnt: got %b want 01", obs_gnt);
        end
        vectors++;
        if (obs_done_cyc != 7) begin
            miscompares++; $display("FAIL up_done_cycle: got %0d want 7", obs_done_cyc);
        end
        vectors++;
        if (obs_done_id !== 1'b0 || obs_done_abort !== 1'b0) begin
            miscompares++; $display("FAIL up_done_info: id=%b abort=%b want 0/0", obs_done_id, obs_done_abort);
        end
        for (int c = 2; c <= 7 && c < obs_cnt.size(); c++) begin
            vectors++;
            if (obs_cnt[c] !== 8'(c + 1 > 7 ? 7 : c + 1)) begin
                miscompares++; $display("FAIL up_cnt[%0d]: got %0d want %0d", c, obs_cnt[c], (c + 1 > 7 ? 7 : c + 1));
            end
        end
        vectors++;
        if (obs_idle_cnt !== 8'd7 || obs_idle_busy !== 1'b0) begin
            miscompares++; $display("FAIL up_idle: cnt=%0d busy=%b want 7/0", obs_idle_cnt, obs_idle_busy);
        end
    endtask

    task automatic test_down_degenerate();
        do_sweep(1'b1, 8'd10, 8'd4, -1);
        vectors++;
        if (obs_gnt !== 2'b10 || obs_done_cyc != 9 || obs_done_id !== 1'b1) begin
            miscompares++;
            $display("FAIL down_sweep: gnt=%b done_cyc=%0d id=%b want 10/9/1", obs_gnt, obs_done_cyc, obs_done_id);
        end
        for (int c = 2; c <= 8 && c < obs_cnt.size(); c++) begin
            vectors++;
            if (obs_cnt[c] !== 8'(12 - c)) begin
                miscompares++; $display("FAIL down_cnt[%0d]: got %0d want %0d", c, obs_cnt[c], 12 - c);
            end
        end
        do_sweep(1'b0, 8'h55, 8'h55, -1);
        vectors++;
        if (obs_done_cyc != 3 || obs_done_abort !== 1'b0) begin
            miscompares++; $display("FAIL degenerate: done_cyc=%0d abort=%b want 3/0", obs_done_cyc, obs_done_abort);
        end
        vectors++;
        if (obs_cnt.size() > 2 && obs_cnt[2] !== 8'h55) begin
            miscompares++; $display("FAIL degenerate_cnt: got %0h want 55", obs_cnt[2]);
        end else if (obs_cnt.size() <= 2) begin
            miscompares++; $display("FAIL degenerate_cnt: got no RUN cycle want 55");
        end
    endtask

    task automatic test_round_robin();
        int g_cyc[$];
        int g_id[$];
        int d_cyc[$];
        int d_id[$];
        int exp_len;
        @(posedge clk); #1;
        rst = 1'b1; #2; rst = 1'b0;
        bus.from0 = 8'd1; bus.to0 = 8'd3; bus.from1 = 8'd9; bus.to1 = 8'd8;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        #1;
        for (int c = 0; c < 200 && d_cyc.size() < 3; c++) begin
            if (bus.gnt != 2'b00) begin
                g_cyc.push_back(c);
                g_id.push_back(bus.gnt == 2'b10 ? 1 : 0);
            end
            if (bus.done) begin
                d_cyc.push_back(c);
                d_id.push_back(int'(bus.done_id));
            end
            @(posedge clk); #1;
            if (g_cyc.size() >= 3) begin
                bus.req0 = 1'b0; bus.req1 = 1'b0;
            end
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        vectors++;
        if (g_cyc.size() != 3 || d_cyc.size() != 3) begin
            miscompares++; $display("FAIL rr_count: grants=%0d dones=%0d want 3/3", g_cyc.size(), d_cyc.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (g_id[k] != (k % 2) || d_id[k] != (k % 2)) begin
                    miscompares++; $display("FAIL rr_id[%0d]: gnt_id=%0d done_id=%0d want %0d", k, g_id[k], d_id[k], k % 2);
                end
                exp_len = (k % 2 == 0) ? model_steps(1, 3) + 3 : model_steps(9, 8) + 3;
                vectors++;
                if (d_cyc[k] - g_cyc[k] != exp_len) begin
                    miscompares++; $display("FAIL rr_len[%0d]: got %0d want %0d", k, d_cyc[k] - g_cyc[k], exp_len);
                end
                if (k > 0) begin
                    vectors++;
                    if (g_cyc[k] != d_cyc[k-1] + 1) begin
                        miscompares++; $display("FAIL rr_spacing[%0d]: got %0d want %0d", k, g_cyc[k], d_cyc[k-1] + 1);
                    end
                end
            end
        end
    endtask

    task automatic test_abort();
        do_sweep(1'b0, 8'h10, 8'h40, 18);
        vectors++;
        if (obs_cnt.size() > 18 && obs_cnt[18] !== 8'h20) begin
            miscompares++; $display("FAIL abort_setup: cnt at abort=%0h want 20", obs_cnt[18]);
        end
        vectors++;
        if (obs_done_cyc != 19 || obs_done_abort !== 1'b1 || obs_done_id !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_done: cyc=%0d abort=%b id=%b want 19/1/0", obs_done_cyc, obs_done_abort, obs_done_id);
        end
        vectors++;
        if (obs_idle_cnt !== 8'h20 || (obs_cnt.size() > 19 && obs_cnt[19] !== 8'h20)) begin
            miscompares++; $display("FAIL abort_hold: idle cnt=%0h want 20", obs_idle_cnt);
        end
    endtask

    task automatic test_wrap();
        int n;
        int dir;
        n   = model_steps(250, 3);
        dir = model_dir(250, 3);
        do_sweep(1'b1, 8'd250, 8'd3, -1);
        vectors++;
        if (obs_done_cyc != n + 3) begin
            miscompares++; $display("FAIL wrap_done_cycle: got %0d want %0d", obs_done_cyc, n + 3);
        end
        for (int c = 2; c <= 4 && c < obs_cnt.size(); c++) begin
            vectors++;
            if (obs_cnt[c] !== 8'(model_val(250, dir, c))) begin
                miscompares++; $display("FAIL wrap_cnt[%0d]: got %0d want %0d", c, obs_cnt[c], model_val(250, dir, c));
            end
        end
        vectors++;
        if (obs_idle_cnt !== 8'd3) begin
            miscompares++; $display("FAIL wrap_end: got %0d want 3", obs_idle_cnt);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 24; k++) begin
            int id, f, t, dl, n, dir, ac, exp_done, last, bad;
            id = int'($urandom_range(0, 1));
            f  = int'($urandom_range(0, 255));
            dl = int'($urandom_range(0, 30));
            t  = ($urandom_range(0, 1) == 1) ? f + dl : f - dl;
            if (t > 255) t = f - dl;
            if (t < 0)   t = f + dl;
            n   = model_steps(f, t);
            dir = model_dir(f, t);
            ac  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, n + 2)) : -1;
            exp_done = (ac >= 0) ? ac + 1 : n + 3;
            last     = (ac >= 0) ? ac : n + 2;
            do_sweep(id[0], 8'(f), 8'(t), ac);
            vectors++;
            if (obs_gnt !== (id == 1 ? 2'b10 : 2'b01) || obs_extra_gnt != 0) begin
                miscompares++; $display("FAIL rnd_gnt[%0d]: got %b extra=%0d want id %0d", k, obs_gnt, obs_extra_gnt, id);
            end
            vectors++;
            if (obs_done_cyc != exp_done) begin
                miscompares++; $display("FAIL rnd_done_cycle[%0d]: got %0d want %0d", k, obs_done_cyc, exp_done);
            end
            vectors++;
            if (obs_done_id !== id[0] || obs_done_abort !== (ac >= 0)) begin
                miscompares++;
                $display("FAIL rnd_done_info[%0d]: id=%b abort=%b want %0d/%0d", k, obs_done_id, obs_done_abort, id, ac >= 0);
            end
            for (int c = 2; c <= last && c < obs_cnt.size(); c++) begin
                vectors++;
                if (obs_cnt[c] !== 8'(model_val(f, dir, c))) begin
                    miscompares++; $display("FAIL rnd_cnt[%0d][%0d]: got %0d want %0d", k, c, obs_cnt[c], model_val(f, dir, c));
                end
            end
            bad = 0;
            for (int c = 0; c < obs_busy.size(); c++)
                if (obs_busy[c] !== (c >= 1 && c < exp_done)) bad++;
            vectors++;
            if (bad != 0) begin
                miscompares++; $display("FAIL rnd_busy[%0d]: got %0d wrong cycles want 0", k, bad);
            end
            vectors++;
            if (obs_idle_cnt !== 8'(model_val(f, dir, last)) || obs_idle_busy !== 1'b0) begin
                miscompares++;
                $display("FAIL rnd_idle[%0d]: cnt=%0d busy=%b want %0d/0", k, obs_idle_cnt, obs_idle_busy, model_val(f, dir, last));
            end
        end
    endtask

    task automatic test_reset_mid_run();
        bus.from0 = 8'd0; bus.to0 = 8'd100; bus.req0 = 1'b1;
        #1;
        vectors++;
        if (bus.gnt !== 2'b01) begin
            miscompares++; $display("FAIL rmr_first_gnt: got %b want 01", bus.gnt);
        end
        @(posedge clk); #1;
        bus.req0 = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.busy !== 1'b0 || bus.cnt_load !== 1'b1 || bus.cnt_cin !== bus.cnt_q || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL rmr_async: busy=%b load=%b cin=%0d q=%0d done=%b want 0/1/cin==q/0",
                     bus.busy, bus.cnt_load, bus.cnt_cin, bus.cnt_q, bus.done);
        end
        bus.from0 = 8'd5; bus.to0 = 8'd6; bus.from1 = 8'd7; bus.to1 = 8'd7;
        bus.req1 = 1'b1; bus.req0 = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        vectors++;
        if (bus.cnt_q !== 8'd4 || bus.done !== 1'b0 || bus.gnt !== 2'b00) begin
            miscompares++; $display("FAIL rmr_hold: cnt=%0d done=%b gnt=%b want 4/0/00", bus.cnt_q, bus.done, bus.gnt);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (bus.gnt !== 2'b01) begin
            miscompares++; $display("FAIL rmr_prio: got %b want 01", bus.gnt);
        end
        @(posedge clk); #1;
        bus.req0 = 1'b0;
        for (int c = 0; c < 60 && !bus.done; c++) begin @(posedge clk); #1; end
        vectors++;
        if (bus.done !== 1'b1 || bus.done_id !== 1'b0) begin
            miscompares++; $display("FAIL rmr_done0: done=%b id=%b want 1/0", bus.done, bus.done_id);
        end
        @(posedge clk); #1;
        vectors++;
        if (bus.gnt !== 2'b10) begin
            miscompares++; $display("FAIL rmr_pending: got %b want 10", bus.gnt);
        end
        @(posedge clk); #1;
        bus.req1 = 1'b0;
        for (int c = 0; c < 60 && !bus.done; c++) begin @(posedge clk); #1; end
        vectors++;
        if (bus.done !== 1'b1 || bus.done_id !== 1'b1 || bus.cnt_q !== 8'd7) begin
            miscompares++; $display("FAIL rmr_done1: done=%b id=%b cnt=%0d want 1/1/7", bus.done, bus.done_id, bus.cnt_q);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at %0t want finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.abort = 1'b0;
        bus.from0 = '0; bus.to0 = '0; bus.from1 = '0; bus.to1 = '0;
        test_reset();
        test_up_sweep();
        test_down_degenerate();
        test_round_robin();
        test_abort();
        test_wrap();
        test_random();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
